sega_joy_scanner: RTL and testbench

//  Sequences the shared joystick select line (joyX_p7_o) to read two DB9 pads: Atari, Master System, Mega Drive 3/6-button.

---
 rtl/sega_joy_pkg.sv | 52 +++++
 rtl/sega_joy_port.sv | 63 ++++++
 rtl/sega_joy_scanner.sv | 69 ++++++
 tb/tb_sega_joy_scanner.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sega_joy_pkg.sv
// Shared constants for the DB9 pad scanner: scan step numbers, button bit
// positions in the published word and raw pin positions.
package sega_joy_pkg;

  localparam int unsigned STEP_W = 8;
  localparam int unsigned JOY_W  = 12;
  localparam int unsigned PIN_W  = 6;

  localparam logic [STEP_W-1:0] S_P7LO0    = 8'd0;
  localparam logic [STEP_W-1:0] S_P7HI0    = 8'd1;
  localparam logic [STEP_W-1:0] S_READ_BC  = 8'd2;
  localparam logic [STEP_W-1:0] S_READ_AS  = 8'd3;
  localparam logic [STEP_W-1:0] S_P7LO2    = 8'd4;
  localparam logic [STEP_W-1:0] S_READ_SIX = 8'd5;
  localparam logic [STEP_W-1:0] S_READ_XYZ = 8'd6;
  localparam logic [STEP_W-1:0] S_PUBLISH  = 8'd7;

  localparam int unsigned JOY_U = 0;
  localparam int unsigned JOY_D = 1;
  localparam int unsigned JOY_L = 2;
  localparam int unsigned JOY_R = 3;
  localparam int unsigned JOY_B = 4;
  localparam int unsigned JOY_C = 5;
  localparam int unsigned JOY_A = 6;
  localparam int unsigned JOY_S = 7;
  localparam int unsigned JOY_Z = 8;
  localparam int unsigned JOY_Y = 9;
  localparam int unsigned JOY_X = 10;
  localparam int unsigned JOY_M = 11;

  localparam int unsigned PIN_U  = 0;
  localparam int unsigned PIN_D  = 1;
  localparam int unsigned PIN_L  = 2;
  localparam int unsigned PIN_R  = 3;
  localparam int unsigned PIN_P6 = 4;
  localparam int unsigned PIN_P9 = 5;

  localparam logic [JOY_W-1:0] JOY_IDLE = 12'hFFF;
  localparam logic [PIN_W-1:0] PIN_IDLE = 6'h3F;

  // Select level to drive after the tick of a given step.
  function automatic logic p7_level(input logic [STEP_W-1:0] step);
    logic lvl;
    lvl = 1'b1;
    case (step)
      S_P7LO0, S_READ_BC, S_P7LO2, S_READ_XYZ: lvl = 1'b0;
      default:                                 lvl = 1'b1;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/sega_joy_port.sv
// One DB9 port: input synchroniser, per-frame assembly of the button word and
// six-button detection, published as a whole at the publish step.
module sega_joy_port
  import sega_joy_pkg::*;
(
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [STEP_W-1:0] step,
  input  logic              tick,
  input  logic [PIN_W-1:0]  pins,
  output logic [JOY_W-1:0]  joy,
  output logic              six
);

  logic [PIN_W-1:0] sync1;
  logic [PIN_W-1:0] sync2;
  logic [JOY_W-1:0] work;
  logic             six_pend;

  // Each read on a tick sees the select level set one full step earlier.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1    <= PIN_IDLE;
      sync2    <= PIN_IDLE;
      work     <= JOY_IDLE;
      six_pend <= 1'b0;
      joy      <= JOY_IDLE;
      six      <= 1'b0;
    end else begin
      sync1 <= pins;
      sync2 <= sync1;
      if (tick) begin
        case (step)
          S_READ_BC: begin
            work[JOY_R:JOY_U] <= sync2[PIN_R:PIN_U];
            work[JOY_C:JOY_B] <= sync2[PIN_P9:PIN_P6];
            six_pend          <= 1'b0;
          end
          S_READ_AS: begin
            // Mega Drive pads pull both L and R low while select is low.
            if (!sync2[PIN_R] && !sync2[PIN_L])
              work[JOY_S:JOY_A] <= sync2[PIN_P9:PIN_P6];
            else
              work[JOY_S:JOY_B] <= {2'b11, sync2[PIN_P9:PIN_P6]};
          end
          S_READ_SIX: begin
            if (sync2[PIN_R:PIN_U] == 4'b0000)
              six_pend <= 1'b1;
          end
          S_READ_XYZ: begin
            work[JOY_M:JOY_Z] <= six_pend ? sync2[PIN_R:PIN_U] : 4'hF;
          end
          S_PUBLISH: begin
            joy <= work;
            six <= six_pend;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/sega_joy_scanner.sv
// Scans two DB9 joystick ports through a shared select line and publishes one
// coherent active-low 12-bit word per pad per frame.
module sega_joy_scanner
  import sega_joy_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1536
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [PIN_W-1:0] joy1_i,
  input  logic [PIN_W-1:0] joy2_i,
  output logic             joy_p7_o,
  output logic [JOY_W-1:0] joy1_o,
  output logic [JOY_W-1:0] joy2_o,
  output logic             joy1_six_o,
  output logic             joy2_six_o,
  output logic             frame_o
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0]  div;
  logic [STEP_W-1:0] step;
  logic              tick;

  assign tick = (div == DIV_LAST);

  // Step sequencer: divider, 8-bit step counter, select line and frame pulse.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div      <= '0;
      step     <= '0;
      joy_p7_o <= 1'b1;
      frame_o  <= 1'b0;
    end else begin
      frame_o <= 1'b0;
      if (tick) begin
        div      <= '0;
        step     <= step + STEP_W'(1);
        joy_p7_o <= p7_level(step);
        frame_o  <= (step == S_PUBLISH);
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  sega_joy_port u_port1 (
    .clk_sys (clk_sys),
    .reset   (reset),
    .step    (step),
    .tick    (tick),
    .pins    (joy1_i),
    .joy     (joy1_o),
    .six     (joy1_six_o)
  );

  sega_joy_port u_port2 (
    .clk_sys (clk_sys),
    .reset   (reset),
    .step    (step),
    .tick    (tick),
    .pins    (joy2_i),
    .joy     (joy2_o),
    .six     (joy2_six_o)
  );

endmodule

// File: tb/tb_sega_joy_scanner.sv
// Bench for sega_joy_scanner: behavioural pads answer the select line, the
// expected word of each frame is queued and checked on every frame pulse.
module tb_sega_joy_scanner;

  localparam int unsigned TD        = 4;
  localparam int unsigned FRAME_CYC = 256 * TD;
  localparam int T_IDLE = 0;
  localparam int T_SMS  = 1;
  localparam int T_MD3  = 2;
  localparam int T_MD6  = 3;
  localparam int HI_TIMEOUT = 12;

  typedef struct packed {
    logic [11:0] w1;
    logic [11:0] w2;
    logic        s1;
    logic        s2;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  joy1_pins;
  logic [5:0]  joy2_pins;
  logic        p7;
  logic [11:0] joy1;
  logic [11:0] joy2;
  logic        six1;
  logic        six2;
  logic        frame;

  int          checks = 0;
  int          failures = 0;
  int          pad_type [2];
  logic [11:0] btn [2];
  int          lows = 0;
  int          hi_cnt = 0;
  logic        prev_p7 = 1'b1;
  frame_t      sb [$];
  frame_t      mon_e;
  longint      cyc = 0;
  longint      last_frame = 0;
  bit          have_last = 0;

  always #5 clk = ~clk;

  sega_joy_scanner #(.TICK_DIV(TD)) dut (
    .clk_sys    (clk),
    .reset      (reset),
    .joy1_i     (joy1_pins),
    .joy2_i     (joy2_pins),
    .joy_p7_o   (p7),
    .joy1_o     (joy1),
    .joy2_o     (joy2),
    .joy1_six_o (six1),
    .joy2_six_o (six2),
    .frame_o    (frame)
  );

  // Pad pins {p9,p6,R,L,D,U}, active-low; buttons b are active-high in output bit order.
  function automatic logic [5:0] pad_pins(int t, logic [11:0] b, logic sel, int n_low);
    logic [5:0] hi_std;
    logic [5:0] lo_std;
    hi_std = ~{b[5], b[4], b[3], b[2], b[1], b[0]};
    lo_std = {~b[7], ~b[6], 2'b00, ~b[1], ~b[0]};
    case (t)
      T_SMS: return hi_std;
      T_MD3: return sel ? hi_std : lo_std;
      T_MD6: begin
        if (sel) return (n_low == 3) ? {~b[5], ~b[4], ~b[11], ~b[10], ~b[9], ~b[8]} : hi_std;
        if (n_low == 3) return {~b[7], ~b[6], 4'b0000};
        if (n_low == 4) return {~b[7], ~b[6], 4'b1111};
        return lo_std;
      end
      default: return 6'h3F;
    endcase
  endfunction

  assign joy1_pins = pad_pins(pad_type[0], btn[0], p7, lows);
  assign joy2_pins = pad_pins(pad_type[1], btn[1], p7, lows);

  // Six-button pad low-pulse counter with idle timeout on a long high select.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (prev_p7 && !p7) lows <= lows + 1;
    if (p7) begin
      if (hi_cnt >= HI_TIMEOUT) lows <= 0;
      if (hi_cnt < 1000) hi_cnt <= hi_cnt + 1;
    end else begin
      hi_cnt <= 0;
    end
    prev_p7 <= p7;
  end

  function automatic logic [11:0] exp_word(int t, logic [11:0] b);
    case (t)
      T_SMS:   return ~(b & 12'h03F);
      T_MD3:   return ~(b & 12'h0FF);
      T_MD6:   return ~b;
      default: return 12'hFFF;
    endcase
  endfunction

  function automatic frame_t cur_exp();
    frame_t f;
    f.w1 = exp_word(pad_type[0], btn[0]);
    f.w2 = exp_word(pad_type[1], btn[1]);
    f.s1 = (pad_type[0] == T_MD6);
    f.s2 = (pad_type[1] == T_MD6);
    return f;
  endfunction

  // Random presses a real pad of that type can produce without faking a detect.
  function automatic logic [11:0] rand_btn(int t);
    logic [11:0] b;
    b = 12'($urandom);
    if ((t == T_MD3 || t == T_MD6) && b[0] && b[1]) b[1] = 1'b0;
    if (t == T_SMS && b[2] && b[3]) b[3] = 1'b0;
    return b;
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic chk_int(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic set_pads(input int t1, input logic [11:0] b1, input int t2, input logic [11:0] b2);
    pad_type[0] = t1;
    btn[0]      = b1;
    pad_type[1] = t2;
    btn[1]      = b2;
    sb.push_back(cur_exp());
  endtask

  task automatic wait_frame();
    bit seen;
    seen = 0;
    for (int i = 0; i < int'(FRAME_CYC) + 64; i++) begin
      @(negedge clk);
      if (frame) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout: no frame pulse within %0d cycles", FRAME_CYC + 64);
    end
  endtask

  task automatic check_first_fall();
    for (int i = 1; i <= int'(TD); i++) begin
      @(negedge clk);
      chk("p7_after_release", {11'b0, p7}, (i < int'(TD)) ? 12'h001 : 12'h000);
    end
  endtask

  task automatic check_reset_state();
    chk("rst_joy1", joy1, 12'hFFF);
    chk("rst_joy2", joy2, 12'hFFF);
    chk("rst_p7", {11'b0, p7}, 12'h001);
    chk("rst_six1", {11'b0, six1}, 12'h000);
    chk("rst_six2", {11'b0, six2}, 12'h000);
    chk("rst_frame", {11'b0, frame}, 12'h000);
  endtask

  // Monitor: every frame pulse consumes one expected frame.
  always @(negedge clk) begin
    if (reset) begin
      have_last = 0;
    end else if (frame) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame: got joy1=%h joy2=%h expected no frame", joy1, joy2);
      end else begin
        mon_e = sb.pop_front();
        chk("joy1", joy1, mon_e.w1);
        chk("joy2", joy2, mon_e.w2);
        chk("six1", {11'b0, six1}, {11'b0, mon_e.s1});
        chk("six2", {11'b0, six2}, {11'b0, mon_e.s2});
      end
      if (have_last) chk_int("frame_spacing", cyc - last_frame, longint'(FRAME_CYC));
      last_frame = cyc;
      have_last  = 1;
    end
  end

  initial begin
    int t1;
    int t2;
    pad_type[0] = T_IDLE;
    pad_type[1] = T_IDLE;
    btn[0] = 12'h000;
    btn[1] = 12'h000;
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check_reset_state();

    // MD 3-button: Up + A + Start on port 1
    set_pads(T_MD3, 12'h0C1, T_IDLE, 12'h000);
    reset = 1'b0;
    check_first_fall();
    wait_frame();

    // Master System pad with button 1 (p6) held
    set_pads(T_SMS, 12'h010, T_IDLE, 12'h000);
    wait_frame();

    // Six-button pad with X on port 2, MD 3-button on port 1
    set_pads(T_MD3, 12'h041, T_MD6, 12'h400);
    wait_frame();

    repeat (12) begin
      t1 = int'($urandom_range(0, 3));
      t2 = int'($urandom_range(0, 3));
      set_pads(t1, rand_btn(t1), t2, rand_btn(t2));
      wait_frame();
    end

    // Right pressed during step 4: must appear only one frame later
    set_pads(T_MD3, 12'h040, T_MD6, rand_btn(T_MD6));
    repeat (1009) @(negedge clk);
    btn[0] = btn[0] | 12'h008;
    sb.push_back(cur_exp());
    wait_frame();
    wait_frame();

    // Reset pulsed during step 4 aborts the scan
    set_pads(T_MD3, 12'h0C1, T_MD6, 12'h900);
    repeat (1009) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    check_reset_state();
    repeat (9) @(negedge clk);
    sb.push_back(cur_exp());
    reset = 1'b0;
    check_first_fall();
    wait_frame();
    set_pads(T_SMS, rand_btn(T_SMS), T_MD6, rand_btn(T_MD6));
    wait_frame();

    repeat (4) @(negedge clk);
    chk_int("scoreboard_empty", longint'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
